// File: rtl/hmmm_controller.sv
// Control unit for the 8-bit HMMM-style processor: holds the upper
// instruction byte, sequences fetch / execute, and decodes the function
// field into every datapath select and enable.
module hmmm_controller (
    input  logic       ph1,
    input  logic       reset,
    input  logic       negative,
    input  logic       zero,
    input  logic [6:0] MemData1,
    output logic [6:0] instr1,
    output logic       RegWLoadSrc,
    output logic       RA1Src,
    output logic       PCEnable,
    output logic       AdrSrc,
    output logic       InstrSrc,
    output logic       RegWrite,
    output logic       TwoRegs,
    output logic       ALUSub,
    output logic [1:0] PCSrc,
    output logic [1:0] RegWriteSrc,
    output logic       MemWrite
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [6:0] instrTemp1;
    logic [3:0] funct;
    logic       branch;
    logic       unconditional;
    logic       regJumpLoc;
    logic       condBranch;

    // Capture the upper instruction byte every cycle so execute sees the fetched word
    always_ff @(posedge ph1) begin
        if (reset) begin
            instrTemp1 <= 7'd0;
        end else begin
            instrTemp1 <= MemData1;
        end
    end

    // State register: fetch/execute sequencing
    always_ff @(posedge ph1) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Instruction select, decode, next state and all control outputs
    always_comb begin
        InstrSrc      = 1'b0;
        instr1        = instrTemp1;
        funct         = 4'd0;
        branch        = 1'b0;
        unconditional = 1'b0;
        regJumpLoc    = 1'b0;
        condBranch    = 1'b0;
        next_state    = FETCH;
        PCEnable      = 1'b0;
        AdrSrc        = 1'b0;
        PCSrc         = 2'b00;
        RA1Src        = 1'b0;
        TwoRegs       = 1'b0;
        ALUSub        = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        RegWriteSrc   = 2'b00;
        RegWLoadSrc   = 1'b0;

        // In fetch the live bus is used so branches can resolve in one cycle
        InstrSrc = ~reset & (state == FETCH);
        instr1   = InstrSrc ? MemData1 : instrTemp1;
        funct    = instr1[6:3];

        branch        = funct[3];
        unconditional = funct[2];
        regJumpLoc    = funct[1];

        case (funct[1:0])
            2'b00:   condBranch = zero;
            2'b01:   condBranch = ~zero;
            2'b10:   condBranch = ~negative & ~zero;
            default: condBranch = negative;
        endcase

        // Branches finish in fetch; everything else spends one cycle in execute
        if (state == FETCH && !branch) begin
            next_state = EXEC;
        end else begin
            next_state = FETCH;
        end

        PCEnable = (state == EXEC) | branch;
        AdrSrc   = (state == EXEC);

        if (branch && (unconditional || condBranch)) begin
            PCSrc = (unconditional && regJumpLoc) ? 2'b10 : 2'b01;
        end

        RA1Src  = branch;
        TwoRegs = funct[1];
        ALUSub  = funct[0];

        // Store strobe is killed combinationally by reset so a store in flight never lands
        MemWrite = (state == EXEC) & (funct == 4'b0010) & ~reset;
        RegWrite = (state == EXEC) & ~branch & (funct[2] | funct[0]);

        if (funct[2]) begin
            RegWriteSrc = 2'b10;
        end else if (funct[1]) begin
            RegWriteSrc = 2'b01;
        end else begin
            RegWriteSrc = 2'b00;
        end

        RegWLoadSrc = (funct == 4'b0011);
    end

endmodule

// File: tb/tb_hmmm_controller.sv
// Self-checking bench for hmmm_controller: directed program steps followed
// by random instructions, compared against an instruction-level model.
module tb_hmmm_controller;

    logic       ph1;
    logic       reset;
    logic       negative;
    logic       zero;
    logic [6:0] MemData1;
    logic [6:0] instr1;
    logic       RegWLoadSrc;
    logic       RA1Src;
    logic       PCEnable;
    logic       AdrSrc;
    logic       InstrSrc;
    logic       RegWrite;
    logic       TwoRegs;
    logic       ALUSub;
    logic [1:0] PCSrc;
    logic [1:0] RegWriteSrc;
    logic       MemWrite;

    int testsRun;
    int failCount;

    // Model state: whether the machine is in its execute cycle, and the latched byte
    bit         mExec;
    logic [6:0] mLatched;

    hmmm_controller dut (
        .ph1         (ph1),
        .reset       (reset),
        .negative    (negative),
        .zero        (zero),
        .MemData1    (MemData1),
        .instr1      (instr1),
        .RegWLoadSrc (RegWLoadSrc),
        .RA1Src      (RA1Src),
        .PCEnable    (PCEnable),
        .AdrSrc      (AdrSrc),
        .InstrSrc    (InstrSrc),
        .RegWrite    (RegWrite),
        .TwoRegs     (TwoRegs),
        .ALUSub      (ALUSub),
        .PCSrc       (PCSrc),
        .RegWriteSrc (RegWriteSrc),
        .MemWrite    (MemWrite)
    );

    // Free-running clock
    initial begin
        ph1 = 1'b0;
        forever #5 ph1 = ~ph1;
    end

    task automatic checkOne(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Instruction currently presented to the decoder, as the ISA describes it
    function automatic logic [6:0] modelInstr();
        return (!reset && !mExec) ? MemData1 : mLatched;
    endfunction

    // Compare every output against what the instruction semantics demand
    task automatic checkOutput();
        logic [6:0] ins;
        int         f;
        bit         isBranch;
        bit         taken;
        bit         writesReg;
        int         expPcSrc;
        int         expRws;
        ins       = modelInstr();
        f         = int'(ins[6:3]);
        isBranch  = (f >= 8);
        case (f)
            8:       taken = zero;
            9:       taken = !zero;
            10:      taken = !negative && !zero;
            11:      taken = negative;
            12, 13, 14, 15: taken = 1;
            default: taken = 0;
        endcase
        expPcSrc  = !taken ? 0 : (f >= 14) ? 2 : 1;
        writesReg = (f == 1) || (f == 3) || (f >= 4 && f <= 7);
        expRws    = ((f % 8) >= 4) ? 2 : ((f % 4) >= 2) ? 1 : 0;

        checkOne("instr1",      instr1,      ins);
        checkOne("InstrSrc",    {6'd0, InstrSrc},    {6'd0, (!reset && !mExec)});
        checkOne("AdrSrc",      {6'd0, AdrSrc},      {6'd0, mExec});
        checkOne("PCEnable",    {6'd0, PCEnable},    {6'd0, (mExec || isBranch)});
        checkOne("PCSrc",       {5'd0, PCSrc},       7'(expPcSrc));
        checkOne("RA1Src",      {6'd0, RA1Src},      {6'd0, isBranch});
        checkOne("TwoRegs",     {6'd0, TwoRegs},     7'((f / 2) % 2));
        checkOne("ALUSub",      {6'd0, ALUSub},      7'(f % 2));
        checkOne("MemWrite",    {6'd0, MemWrite},    {6'd0, (mExec && f == 2 && !reset)});
        checkOne("RegWrite",    {6'd0, RegWrite},    {6'd0, (mExec && !isBranch && writesReg)});
        checkOne("RegWriteSrc", {5'd0, RegWriteSrc}, 7'(expRws));
        checkOne("RegWLoadSrc", {6'd0, RegWLoadSrc}, {6'd0, (f == 3)});
    endtask

    // Drive one cycle's inputs away from the rising edge and let them settle
    task automatic applyStimulus(input bit rst, input bit neg, input bit zr, input logic [6:0] bus);
        @(negedge ph1);
        reset    = rst;
        negative = neg;
        zero     = zr;
        MemData1 = bus;
        #1;
    endtask

    // Advance the model across the rising edge
    task automatic tick();
        logic [6:0] ins;
        ins = modelInstr();
        @(posedge ph1);
        if (reset) begin
            mExec    = 0;
            mLatched = 7'd0;
        end else begin
            mExec    = !mExec && !ins[6];
            mLatched = MemData1;
        end
    endtask

    task automatic step(input bit rst, input bit neg, input bit zr, input logic [6:0] bus);
        applyStimulus(rst, neg, zr, bus);
        checkOutput();
        tick();
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        mExec     = 0;
        mLatched  = 7'd0;
        reset     = 1'b1;
        negative  = 1'b0;
        zero      = 1'b0;
        MemData1  = 7'h7F;

        // Reset held two edges; before the first edge internal state is unknown
        applyStimulus(1, 0, 0, 7'h7F);
        checkOne("rst_MemWrite", {6'd0, MemWrite}, 7'd0);
        checkOne("rst_InstrSrc", {6'd0, InstrSrc}, 7'd0);
        tick();
        step(1, 0, 0, 7'h7F);
        checkOne("rst_instr1", instr1, 7'd0);

        // Store: fetch, then execute with the bus moved on
        applyStimulus(0, 0, 0, 7'b0010011);
        checkOutput();
        checkOne("st_fetch_MemWrite", {6'd0, MemWrite}, 7'd0);
        tick();
        applyStimulus(0, 0, 0, 7'h55);
        checkOutput();
        checkOne("st_exec_instr1",   instr1, 7'b0010011);
        checkOne("st_exec_MemWrite", {6'd0, MemWrite}, 7'd1);
        tick();
        step(0, 0, 0, 7'b0011000);
        applyStimulus(0, 0, 0, 7'h00);
        checkOutput();
        checkOne("ld_exec_RegWriteSrc", {5'd0, RegWriteSrc}, 7'd1);
        tick();

        // Arithmetic, set-immediate and nop, each fetch+execute
        step(0, 0, 0, 7'b0110101); step(0, 0, 0, 7'h00);
        step(0, 1, 0, 7'b0111010); step(0, 1, 0, 7'h00);
        step(0, 0, 0, 7'b0001111); step(0, 0, 0, 7'h00);
        step(0, 0, 0, 7'b0000001); step(0, 0, 0, 7'h00);

        // Conditional branches, taken and not taken, staying in fetch
        step(0, 0, 1, 7'b1000001);
        step(0, 0, 0, 7'b1000001);
        step(0, 0, 0, 7'b1001010);
        step(0, 0, 1, 7'b1001010);
        step(0, 0, 0, 7'b1010011);
        step(0, 0, 1, 7'b1010011);
        step(0, 1, 0, 7'b1010011);
        step(0, 1, 0, 7'b1011100);
        step(0, 0, 0, 7'b1011100);
        applyStimulus(0, 0, 0, 7'b1011100);
        checkOne("br_stays_fetch", {6'd0, AdrSrc}, 7'd0);
        checkOutput();
        tick();

        // Unconditional branches
        step(0, 0, 0, 7'b1100000);
        step(0, 1, 1, 7'b1110000);
        applyStimulus(0, 0, 1, 7'b1110000);
        checkOne("jr_PCSrc", {5'd0, PCSrc}, 7'd2);
        tick();

        // Reset arriving during a store's execute cycle
        step(0, 0, 0, 7'b0010000);
        applyStimulus(1, 0, 0, 7'h00);
        checkOne("rst_store_MemWrite", {6'd0, MemWrite}, 7'd0);
        checkOutput();
        tick();
        applyStimulus(0, 0, 0, 7'b0110000);
        checkOne("rst_store_fetch", {6'd0, AdrSrc}, 7'd0);
        checkOutput();
        tick();

        // Random program with occasional resets
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 7'($urandom_range(0, 127)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/hmmm_controller.md
Name: hmmm_controller

Overview:
- Control unit of the 8-bit HMMM-style processor. It decodes the 4-bit function field of the instruction and sequences a two-state cycle: instruction fetch, then load/store/write-back.
- It holds the upper instruction byte, bits 14:8, and passes it to the datapath. It drives every datapath select and enable, plus the memory write strobe.
- Branch instructions complete in the fetch state. All other instructions take two cycles.

Parameters:
- None. All widths are fixed.

Ports:
- ph1  input  1  single system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- negative  input  1  RD1[7] from the datapath
- zero  input  1  high when RD1 == 0
- MemData1  input  7  memory data bus bits 14:8, the upper instruction field
- instr1  output  7  current instruction bits 14:8; bits 10:8 give the register select
- RegWLoadSrc  output  1  datapath load-path select
- RA1Src  output  1  read-address-1 select
- PCEnable  output  1  PC register enable
- AdrSrc  output  1  address select: 0 = PC, 1 = RD2
- InstrSrc  output  1  1 = pass the live memory bus through, 0 = use the registered instruction
- RegWrite  output  1  register-file write enable
- TwoRegs  output  1  ALU source A: 1 = RD1, 0 = zero
- ALUSub  output  1  ALU subtract, which inverts B and sets carry-in
- PCSrc  output  2  00 = PC+1, 01 = immediate, 10 = RD1
- RegWriteSrc  output  2  00 = immediate, 01 = memory data, 10 = ALU result
- MemWrite  output  1  memory write strobe

Behaviour:
- Instruction register:
  - 7-bit register instrTemp1 captures MemData1 on every rising edge of ph1.
  - reset loads it with 0.
  - instr1 = InstrSrc ? MemData1 : instrTemp1.
- funct = instr1[14:11]. All decode outputs below are combinational from funct, state, reset, negative and zero.
- State flop `state`, where 0 = fetch and 1 = execute/write-back:
  - Next state = ~state & ~branch.
  - reset forces 0.
  - Result: fetch→execute→fetch for non-branches; fetch→fetch for branches.
- Sequencing outputs:
  - PCEnable = state | branch.
  - AdrSrc = state.
  - InstrSrc = ~reset & ~state.
- Branch decode:
  - branch = funct[3], unconditional = funct[2], regJumpLoc = funct[1].
  - condBranch is selected by funct[1:0]:
    - 00 → zero
    - 01 → ~zero
    - 10 → ~negative & ~zero
    - 11 → negative
- PCSrc:
  - 00 unless branch & (unconditional | condBranch).
  - When taken: 10 if unconditional & regJumpLoc, else 01.
  - The value 11 is never produced.
- RA1Src = branch.
- ALU decode: TwoRegs = funct[1]; ALUSub = funct[0].
- MemWrite = state & (funct == 4'b0010) & ~reset.
- RegWrite = state & ~branch & (funct[2] | funct[0]).
- RegWriteSrc, by priority: funct[2] → 10; else funct[1] → 01; else 00.
- RegWLoadSrc = (funct == 4'b0011). It is independent of state.
- Reset values:
  - state = 0 and instrTemp1 = 0, so instr1 = 0 and funct = 0.
  - MemWrite, RegWrite, PCEnable, AdrSrc and InstrSrc are 0.
  - PCSrc = 00, RegWriteSrc = 00.
- Reset mid-operation: the next edge returns to fetch. Any in-flight store is suppressed immediately, because MemWrite is gated by ~reset.
- The decode outputs (TwoRegs, ALUSub, RegWriteSrc, RA1Src, RegWLoadSrc) also follow funct in the fetch state. The datapath only uses them when the matching enables are active.

Test Plan:
1. Hold reset for 2 edges with MemData1=7'h7F:
   - During reset: MemWrite=0, InstrSrc=0.
   - After the first edge: instr1=0, PCEnable=0, PCSrc=00, RegWrite=0, state=0.
2. Store, MemData1=7'b0010_011, after reset is released:
   - Fetch: InstrSrc=1, instr1=7'b0010011, AdrSrc=0, PCEnable=0, MemWrite=0.
   - Next cycle, with the bus changed to 7'h55: instr1 stays 7'b0010011, AdrSrc=1, PCEnable=1, MemWrite=1, RegWrite=0.
   - Following cycle: back in fetch.
3. Load, funct 0011, in the execute cycle: RegWrite=1, RegWriteSrc=01, RegWLoadSrc=1, TwoRegs=1, ALUSub=1, MemWrite=0.
4. Arithmetic:
   - funct 0110 (add), execute cycle: RegWrite=1, RegWriteSrc=10, TwoRegs=1, ALUSub=0.
   - funct 0111 (sub): ALUSub=1.
   - funct 0001 (set immediate): RegWrite=1, RegWriteSrc=00.
   - funct 0000: RegWrite=0.
5. Conditional branches, each staying in fetch (state remains 0), with PCEnable=1, RA1Src=1, RegWrite=0:
   - funct 1000 with zero=1: PCSrc=01. With zero=0: PCSrc=00.
   - funct 1001: taken when zero=0.
   - funct 1010: taken when negative=0 and zero=0; not taken when zero=1.
   - funct 1011: taken when negative=1.
6. Unconditional branches:
   - funct 1100: PCSrc=01.
   - funct 1110: PCSrc=10, regardless of negative and zero.
   - Assert reset during the execute cycle of a store: MemWrite drops to 0 immediately and state=0 after the edge.
